// File: rtl/reg_bank_ctrl.sv
// rtl/reg_bank_ctrl.sv - sixteen-entry register bank with mux-driven move/load sequencer
module reg_bank_ctrl #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              start,
    input  logic              ext,
    input  logic [3:0]        src,
    input  logic [3:0]        dst,
    output logic [4:0]        mux_sel,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] r0,
    output logic [DATA_W-1:0] r1,
    output logic [DATA_W-1:0] r2,
    output logic [DATA_W-1:0] r3,
    output logic [DATA_W-1:0] r4,
    output logic [DATA_W-1:0] r5,
    output logic [DATA_W-1:0] r6,
    output logic [DATA_W-1:0] r7,
    output logic [DATA_W-1:0] r8,
    output logic [DATA_W-1:0] r9,
    output logic [DATA_W-1:0] r10,
    output logic [DATA_W-1:0] r11,
    output logic [DATA_W-1:0] r12,
    output logic [DATA_W-1:0] r13,
    output logic [DATA_W-1:0] r14,
    output logic [DATA_W-1:0] r15
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_LATCH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        src_q, src_d;
    logic [3:0]        dst_q, dst_d;
    logic              ext_q, ext_d;
    logic [4:0]        mux_sel_d;
    logic              busy_d;
    logic              done_d;
    logic              wr_en;
    logic [DATA_W-1:0] regs [16];

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        ext_d     = ext_q;
        mux_sel_d = 5'd0;
        wr_en     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dst_d = dst;
                    ext_d = ext;
                    if (ext) begin
                        state_d = S_LATCH;
                    end else begin
                        src_d   = src;
                        state_d = S_DRIVE;
                    end
                end
            end
            S_DRIVE: state_d = S_LATCH;
            S_LATCH: begin
                wr_en   = 1'b1;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Outputs are registered, so they are derived from the state being entered.
        if (state_d == S_DRIVE || (state_d == S_LATCH && !ext_d)) begin
            mux_sel_d = {1'b0, src_d} + 5'd1;
        end
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            src_q   <= 4'd0;
            dst_q   <= 4'd0;
            ext_q   <= 1'b0;
            mux_sel <= 5'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            ext_q   <= ext_d;
            mux_sel <= mux_sel_d;
            busy    <= busy_d;
            done    <= done_d;
            if (wr_en) begin
                regs[dst_q] <= bus_in;
            end
        end
    end

    assign r0  = regs[0];
    assign r1  = regs[1];
    assign r2  = regs[2];
    assign r3  = regs[3];
    assign r4  = regs[4];
    assign r5  = regs[5];
    assign r6  = regs[6];
    assign r7  = regs[7];
    assign r8  = regs[8];
    assign r9  = regs[9];
    assign r10 = regs[10];
    assign r11 = regs[11];
    assign r12 = regs[12];
    assign r13 = regs[13];
    assign r14 = regs[14];
    assign r15 = regs[15];

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// tb/tb_reg_bank_ctrl.sv - scoreboard bench for reg_bank_ctrl
module tb_reg_bank_ctrl;

    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] bus_in;
    logic [DATA_W-1:0] bus_drv;
    logic              start;
    logic              ext;
    logic [3:0]        src;
    logic [3:0]        dst;
    logic [4:0]        mux_sel;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rr [16];

    typedef struct {
        int                d;
        logic [DATA_W-1:0] v;
    } sb_item_t;

    sb_item_t          sb [$];
    logic [DATA_W-1:0] exp_r [16];
    int                checks   = 0;
    int                failures = 0;

    always #5 clk = ~clk;

    // Downstream mux model: code 0 leaves the bench-driven external value on the bus.
    always_comb begin
        bus_in = bus_drv;
        if (mux_sel >= 5'd1 && mux_sel <= 5'd16) bus_in = rr[mux_sel - 5'd1];
    end

    reg_bank_ctrl #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .bus_in(bus_in), .start(start), .ext(ext),
        .src(src), .dst(dst), .mux_sel(mux_sel), .busy(busy), .done(done),
        .r0(rr[0]), .r1(rr[1]), .r2(rr[2]), .r3(rr[3]),
        .r4(rr[4]), .r5(rr[5]), .r6(rr[6]), .r7(rr[7]),
        .r8(rr[8]), .r9(rr[9]), .r10(rr[10]), .r11(rr[11]),
        .r12(rr[12]), .r13(rr[13]), .r14(rr[14]), .r15(rr[15])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input logic [DATA_W-1:0] v);
        sb_item_t it;
        it.d = d;
        it.v = v;
        sb.push_back(it);
    endtask

    task automatic do_ext(input int d, input logic [DATA_W-1:0] v);
        start = 1'b1; ext = 1'b1; dst = 4'(d); bus_drv = v;
        push(d, v);
        tick;
        start = 1'b0;
        chk("ext_latch_busy", 32'(busy), 32'd1);
        chk("ext_latch_mux", 32'(mux_sel), 32'd0);
        chk("ext_latch_done", 32'(done), 32'd0);
        tick;
        bus_drv = 16'h5A5A;
        chk("ext_done_pulse", 32'(done), 32'd1);
        chk("ext_done_mux", 32'(mux_sel), 32'd0);
        chk("ext_written", 32'(rr[d]), 32'(v));
        tick;
        chk("ext_idle_busy", 32'(busy), 32'd0);
        chk("ext_idle_done", 32'(done), 32'd0);
    endtask

    task automatic do_move(input int s, input int d, input logic [DATA_W-1:0] v,
                           input logic [4:0] exp_mux, input bit inj);
        start = 1'b1; ext = 1'b0; src = 4'(s); dst = 4'(d); bus_drv = 16'hDEAD;
        push(d, v);
        tick;
        start = 1'b0;
        chk("mv_drive_busy", 32'(busy), 32'd1);
        chk("mv_drive_mux", 32'(mux_sel), 32'(exp_mux));
        if (inj) begin
            start = 1'b1; src = 4'd0; dst = 4'd1;
        end
        tick;
        start = 1'b0;
        chk("mv_latch_mux", 32'(mux_sel), 32'(exp_mux));
        chk("mv_latch_done", 32'(done), 32'd0);
        tick;
        chk("mv_done_pulse", 32'(done), 32'd1);
        chk("mv_done_mux", 32'(mux_sel), 32'd0);
        chk("mv_written", 32'(rr[d]), 32'(v));
        if (inj) begin
            start = 1'b1; ext = 1'b1; dst = 4'd2; bus_drv = 16'h1111;
        end
        tick;
        chk("mv_idle_busy", 32'(busy), 32'd0);
        chk("mv_idle_done", 32'(done), 32'd0);
        if (inj) begin
            push(2, 16'h1111);
            tick;
            start = 1'b0;
            chk("late_start_busy", 32'(busy), 32'd1);
            tick;
            chk("late_start_done", 32'(done), 32'd1);
            chk("late_start_r2", 32'(rr[2]), 32'h1111);
            chk("reject_r1", 32'(rr[1]), 32'd0);
            tick;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ext = 1'b0; src = 4'd0; dst = 4'd0; bus_drv = 16'h7777;
        fork
            forever begin
                @(negedge clk);
                chk("mux_range", 32'(mux_sel <= 5'd16), 32'd1);
                if (rst) begin
                    for (int i = 0; i < 16; i++) exp_r[i] = '0;
                end
                if (done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 32'(done), 32'd0);
                    end else begin
                        sb_item_t it;
                        it = sb.pop_front();
                        exp_r[it.d] = it.v;
                        for (int i = 0; i < 16; i++) chk($sformatf("sb_r%0d", i), 32'(rr[i]), 32'(exp_r[i]));
                    end
                end
            end
        join_none

        tick;
        tick;
        for (int i = 0; i < 16; i++) chk($sformatf("rst_r%0d", i), 32'(rr[i]), 32'd0);
        chk("rst_mux", 32'(mux_sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        rst = 1'b0;
        do_ext(4, 16'h4444);
        do_ext(5, 16'hBEEF);
        do_move(5, 12, 16'hBEEF, 5'd6, 1'b1);
        chk("mv_src_kept", 32'(rr[5]), 32'hBEEF);

        start = 1'b1; ext = 1'b1; dst = 4'd3; bus_drv = 16'h1234;
        tick;
        start = 1'b0;
        chk("abort_latch_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_r3", 32'(rr[3]), 32'd0);
        chk("abort_r12", 32'(rr[12]), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_mux", 32'(mux_sel), 32'd0);
        tick;
        chk("abort_no_done", 32'(done), 32'd0);
        chk("abort_idle", 32'(busy), 32'd0);

        do_ext(15, 16'hFFFF);
        do_move(15, 0, 16'hFFFF, 5'd16, 1'b0);
        do_ext(7, 16'hA5A5);
        do_move(7, 7, 16'hA5A5, 5'd8, 1'b0);
        chk("self_r7", 32'(rr[7]), 32'hA5A5);

        tick;
        tick;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_bank_ctrl.md
REG_BANK_CTRL -- requirements
Module: reg_bank_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning register and bus width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port bus_in, input, DATA_W bits: current value of the shared data bus, driven by the downstream register-select mux.
REQ-005 SHALL have port start, input, 1 bit: request a transfer, sampled in IDLE only.
REQ-006 SHALL have port ext, input, 1 bit: qualifies start; 1 means load dst from an external bus value, 0 means register-to-register move.
REQ-007 SHALL have port src, input, 4 bits: source register index 0..15, captured on an accepted start.
REQ-008 SHALL have port dst, input, 4 bits: destination register index 0..15, captured on an accepted start.
REQ-009 SHALL have port mux_sel, output, 5 bits: select code for the downstream mux; 0 means no source/wait, 1..16 select r0..r15.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-012 SHALL have ports r0..r15, output, DATA_W bits each: registered contents of the 16 registers, fed to the mux.

Function
REQ-013 SHALL implement states IDLE, DRIVE, LATCH, DONE; all outputs registered.
REQ-014 IDLE: start=1 and ext=0 SHALL capture src/dst and go to DRIVE; start=1 and ext=1 SHALL capture dst and go to LATCH; start=0 SHALL stay in IDLE.
REQ-015 DRIVE SHALL hold mux_sel = src+1 for one cycle (bus settle), then go to LATCH.
REQ-016 LATCH SHALL write bus_in into r[dst] at the end of the cycle, then go to DONE; mux_sel SHALL stay src+1 for a move and 0 for ext.
REQ-017 DONE SHALL assert done for exactly one cycle, set mux_sel=0, and return to IDLE.
REQ-018 Latency SHALL be: move accepted at edge N gives the write at edge N+2 and done high during cycle N+3; ext gives the write at N+1 and done during N+2.
REQ-019 start while busy SHALL be ignored; it SHALL NOT be queued, and captured src/dst SHALL NOT change.
REQ-020 src==dst SHALL rewrite the register with its own value (no change observable).
REQ-021 Only r[dst] SHALL change on a write; all other registers SHALL hold.
REQ-022 A new start in the cycle done is high SHALL be ignored; a start SHALL be accepted on the next IDLE cycle.
REQ-023 mux_sel SHALL never exceed 16 and SHALL be 0 in IDLE and DONE.
REQ-024 bus_in SHALL be sampled only in LATCH; bus_in values in other states SHALL have no effect.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, r0..r15=0, mux_sel=0, busy=0, done=0, with priority over every other input.
REQ-026 rst asserted mid-transfer (DRIVE or LATCH) SHALL abort it: no register write in that cycle, and no done pulse.
REQ-027 The first start SHALL be accepted on the first edge with rst=0.

Verification
REQ-028 Reset then idle: rst high 2 cycles -> all r*=0, mux_sel=0, busy=0, done=0.
REQ-029 Ext load: start=1, ext=1, dst=5, bus_in=16'hBEEF -> r5=BEEF after edge N+1, done during N+2, mux_sel=0 throughout.
REQ-030 Move: r5=BEEF, start, ext=0, src=5, dst=12, bench models the mux (bus_in=r[mux_sel-1]) -> mux_sel=6 in DRIVE/LATCH, r12=BEEF at N+2, done at N+3, r5 unchanged.
REQ-031 Busy rejection: second start (src=0, dst=1) issued during DRIVE -> ignored, r1 unchanged, only one done pulse.
REQ-032 Reset mid-op: rst asserted in LATCH of an ext load to r3 with bus_in=1234 -> r3=0, no done, IDLE next cycle.
REQ-033 Boundary: ext load r15=FFFF, then move src=15, dst=0 -> mux_sel=16, r0=FFFF; move src=dst=7 -> r7 unchanged.
